// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: first-word-fall-through head,
// count-based status and a sticky overrun flag for bytes dropped while full.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_tick,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    input  logic                  flush,
    input  logic                  clr_ovr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overrun
);

    localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   AF_LVL  = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  wr_en, rd_en, ovr_set;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH);
    assign almost_full = (count_q >= AF_LVL);
    assign count       = count_q;
    assign overrun     = overrun_q;
    assign rdata       = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        ovr_set   = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_en   = rd && !empty;
            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            wr_en   = wr_tick && (!full || rd);
            ovr_set = wr_tick && full && !rd;

            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (wr_en && !rd_en)      count_d = count_q + CNT_ONE;
            else if (rd_en && !wr_en) count_d = count_q - CNT_ONE;
        end

        if (ovr_set)      overrun_d = 1'b1;
        else if (clr_ovr) overrun_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage carries no reset; only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized + directed bench for uart_rx_fifo: a queue scoreboard holds expected
// read bytes, a count/overrun model holds expected status, a monitor compares.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_tick = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd = 1'b0;
    logic          flush = 1'b0;
    logic          clr_ovr = 1'b0;
    logic [DW-1:0] rdata;
    logic          empty, full, almost_full, overrun;
    logic [AW:0]   count;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [DW-1:0] sb_q[$];
    int            m_cnt = 0;
    bit            m_ovr = 1'b0;
    bit            mon_en = 1'b0;

    uart_rx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF)) dut (
        .clk(clk), .reset(reset), .wr_tick(wr_tick), .wr_data(wr_data), .rd(rd),
        .flush(flush), .clr_ovr(clr_ovr), .rdata(rdata), .empty(empty), .full(full),
        .almost_full(almost_full), .count(count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: status against the model every cycle, head byte against the scoreboard on pops.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", int'(count), m_cnt);
            chk("empty", int'(empty), int'(m_cnt == 0));
            chk("full", int'(full), int'(m_cnt == DEPTH));
            chk("almost_full", int'(almost_full), int'(m_cnt >= AF));
            chk("overrun", int'(overrun), int'(m_ovr));
            if (m_cnt == 0) chk("rdata_empty", int'(rdata), 0);
            if (rd && !flush && m_cnt > 0) begin
                if (sb_q.size() == 0) chk("scoreboard_underflow", 1, 0);
                else chk("rdata_pop", int'(rdata), int'(sb_q.pop_front()));
            end
        end
    end

    // Drive one cycle of inputs, then apply the FIFO rules to the model at the edge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                        input bit f, input bit c);
        bit set;
        wr_tick = w; wr_data = d; rd = r; flush = f; clr_ovr = c;
        @(posedge clk);
        set = 1'b0;
        if (f) begin
            m_cnt = 0;
            sb_q.delete();
        end else begin
            bit accept = w && (m_cnt < DEPTH || r);
            bit pop    = r && m_cnt > 0;
            set = w && m_cnt == DEPTH && !r;
            if (accept) sb_q.push_back(d);
            m_cnt = m_cnt + int'(accept) - int'(pop);
        end
        if (set) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
        #1;
    endtask

    task automatic wr_b(input logic [DW-1:0] d); step(1, d, 0, 0, 0); endtask
    task automatic pop1(); step(0, '0, 1, 0, 0); endtask
    task automatic idle(); step(0, '0, 0, 0, 0); endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_af"}, int'(almost_full), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_rdata"}, int'(rdata), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected finish before 1000000");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;
        mon_en = 1'b1;

        // Basic FWFT ordering.
        wr_b(8'h41); wr_b(8'h42); wr_b(8'h43);
        chk("head_first", int'(rdata), 8'h41);
        repeat (3) pop1();
        idle();

        // Fill, overrun on 17th byte, drain.
        for (int i = 0; i < DEPTH; i++) wr_b(DW'(i));
        wr_b(8'hAA);
        repeat (DEPTH) pop1();
        step(0, '0, 0, 0, 1);

        // Full with simultaneous write/read, then drain through the wrap.
        for (int i = 0; i < DEPTH; i++) wr_b(DW'(8'h60 + i));
        step(1, 8'h55, 1, 0, 0);
        repeat (DEPTH) pop1();

        // Empty with simultaneous read/write, then a lone read on empty.
        step(1, 8'h7E, 1, 0, 0);
        chk("empty_rw_head", int'(rdata), 8'h7E);
        pop1();
        pop1();

        // Overrun set beats clear, clear alone next.
        for (int i = 0; i < DEPTH; i++) wr_b(DW'($urandom));
        wr_b(8'h11);
        step(1, 8'h22, 0, 0, 1);
        step(0, '0, 0, 0, 1);

        // Flush overrides write, leaves overrun alone in both states.
        step(0, '0, 0, 1, 0);
        for (int i = 0; i < 5; i++) wr_b(DW'(8'hB0 + i));
        step(1, 8'h99, 0, 1, 0);
        idle();
        for (int i = 0; i < DEPTH + 1; i++) wr_b(DW'($urandom));
        step(1, 8'h99, 1, 1, 0);
        idle();

        // Randomized phases alternating between fill-heavy and drain-heavy traffic.
        for (int ph = 0; ph < 24; ph++) begin
            int unsigned wp = (ph % 2 == 0) ? 80 : 30;
            int unsigned rp = (ph % 2 == 0) ? 25 : 75;
            for (int n = 0; n < 60; n++) begin
                step($urandom_range(99) < wp, DW'($urandom), $urandom_range(99) < rp,
                     $urandom_range(99) < 2, $urandom_range(99) < 6);
            end
        end

        // Asynchronous reset in the middle of a write with the FIFO full and overrun set.
        for (int i = 0; i < DEPTH + 1; i++) wr_b(DW'($urandom));
        mon_en = 1'b0;
        wr_tick = 1'b1; wr_data = 8'hC3; rd = 1'b0; flush = 1'b0; clr_ovr = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset_outputs("midreset");
        @(posedge clk);
        #1;
        chk_reset_outputs("held_reset");
        reset = 1'b0;
        wr_tick = 1'b0;
        m_cnt = 0; m_ovr = 1'b0; sb_q.delete();
        mon_en = 1'b1;
        wr_b(8'h5A);
        pop1();
        idle();

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART receiver.
- Captures each byte presented with the receiver's one-cycle done pulse into a circular FIFO.
- Exposes first-word-fall-through read data and status (empty, full, almost-full, count, sticky overrun) to the bus-side UART register block.
- Lets the CPU drain bytes at its own pace without losing back-to-back frames.

Parameters:
- DATA_WIDTH, 8: width of each stored byte.
- ADDR_WIDTH, 4: log2 of FIFO depth; depth = 2**ADDR_WIDTH = 16.
- AF_THRESH, 12: almost_full asserts when count >= AF_THRESH; legal range 1..depth.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_tick  input  1  one-cycle write strobe; connects to the receiver's rx_done_tick.
- wr_data  input  DATA_WIDTH  byte to store; sampled only when wr_tick=1.
- rd  input  1  one-cycle pop strobe from the register block.
- flush  input  1  synchronous empty request.
- clr_ovr  input  1  clears the sticky overrun flag.
- rdata  output  DATA_WIDTH  head-of-queue byte; first-word-fall-through.
- empty  output  1  count == 0.
- full  output  1  count == depth.
- almost_full  output  1  count >= AF_THRESH.
- count  output  ADDR_WIDTH+1  number of stored bytes, 0..depth.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Storage and pointers:
  - Memory array of depth entries; the array itself is not reset.
  - wr_ptr and rd_ptr are ADDR_WIDTH bits wide and wrap naturally from depth-1 to 0.
  - count is held in a separate register. Full and empty are derived from count, never from pointer equality.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - wr_ptr=0, rd_ptr=0, count=0, overrun=0.
  - Outputs: empty=1, full=0, almost_full=0, rdata=0.
- Write:
  - Accepted when wr_tick=1 and (full=0 or rd=1).
  - On accept: mem[wr_ptr] <= wr_data; wr_ptr += 1.
- Read:
  - Accepted when rd=1 and empty=0; rd_ptr += 1.
  - rd while empty is ignored: no pointer change, no error flag.
- rdata:
  - Combinational mem[rd_ptr] when empty=0; forced to 0 when empty=1.
  - After a pop, the next entry appears in the same cycle the pop registers (zero-latency head).
  - A byte written into an empty FIFO is visible on rdata the cycle after wr_tick.
- count update:
  - +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous read and write:
  - Not empty: both occur, count unchanged.
  - Empty: only the write occurs; count becomes 1.
  - Full: both occur, count stays depth, no overrun.
- Overrun:
  - Set when wr_tick=1, full=1, rd=0. The byte is dropped; memory and pointers are unchanged.
  - Cleared by clr_ovr=1.
  - If set and clear happen in the same cycle, set wins (overrun=1).
- flush:
  - Sets wr_ptr=rd_ptr=0 and count=0 next cycle.
  - Overrides rd and wr_tick in the same cycle: the byte is discarded and does not set overrun.
  - Does not alter overrun.
- Status outputs (empty, full, almost_full) are combinational decodes of registered count; no extra latency.
- No state machine beyond pointer/count control. Control priority: reset > flush > read/write.

Test Plan:
- Reset, then write 0x41,0x42,0x43 on separate cycles -> count=3, empty=0, rdata=0x41; pop three times -> rdata 0x42, 0x43, then empty=1, rdata=0.
- Write 16 bytes 0x00..0x0F -> almost_full asserts when count reaches 12, full=1 at 16; 17th wr_tick with 0xAA -> overrun=1, count=16; draining yields 0x00..0x0F with no 0xAA.
- Full FIFO, wr_tick(0x55) and rd in the same cycle -> count stays 16, overrun stays 0; the last popped byte after a full drain is 0x55; pointers wrap cleanly through index 15 -> 0.
- Empty FIFO, rd and wr_tick(0x7E) in the same cycle -> count=1, rdata=0x7E; a further lone rd on empty -> count stays 0, no flag.
- overrun=1 with a new overrun event and clr_ovr in the same cycle -> overrun stays 1; clr_ovr alone the next cycle -> overrun=0.
- Load 5 bytes, then assert flush with wr_tick(0x99) in the same cycle -> count=0, empty=1, overrun unchanged; assert reset mid-write -> all outputs return immediately to their reset values.
